// File: rtl/rgmii_idelay_ctrl_pkg.sv
// Shared encodings for the RGMII IDELAY controller. The bench imports this
// package too, so it uses the same op and state values as the RTL.
package rgmii_idelay_ctrl_pkg;

  localparam logic [1:0] OP_LOAD     = 2'd0;
  localparam logic [1:0] OP_INC      = 2'd1;
  localparam logic [1:0] OP_DEC      = 2'd2;
  localparam logic [1:0] OP_LOAD_ALL = 2'd3;

  localparam logic [2:0] ST_WAIT_RDY    = 3'd0;
  localparam logic [2:0] ST_LOAD_SHADOW = 3'd1;
  localparam logic [2:0] ST_IDLE        = 3'd2;
  localparam logic [2:0] ST_APPLY       = 3'd3;
  localparam logic [2:0] ST_SETTLE      = 3'd4;

endpackage

// File: rtl/rgmii_idelay_ctrl.sv
// Runtime tap controller for a bank of VAR_LOAD IDELAYE2 lanes. Keeps a shadow
// of every tap and reloads it into the delay lines whenever IDELAYCTRL comes ready.
module rgmii_idelay_ctrl
  import rgmii_idelay_ctrl_pkg::*;
#(
  parameter int LANES         = 5,
  parameter int TAP_WIDTH     = 5,
  parameter int INIT_TAP      = 0,
  parameter int SETTLE_CYCLES = 16,
  parameter int LANE_W        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           idelayctrl_rdy,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [LANE_W-1:0]              cmd_lane,
  input  logic [TAP_WIDTH-1:0]           cmd_tap,
  output logic [LANES-1:0]               dly_ld,
  output logic [LANES-1:0]               dly_ce,
  output logic                           dly_inc,
  output logic [LANES*TAP_WIDTH-1:0]     dly_cntvaluein,
  output logic [LANES*TAP_WIDTH-1:0]     tap_value,
  output logic                           init_done,
  output logic                           err_sat,
  output logic                           err_lane
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TAP_WIDTH-1:0] TAP_INIT    = TAP_WIDTH'(INIT_TAP);
  localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic                              rdy_meta, rdy_sync;
  logic [2:0]                        state;
  logic [CNT_W-1:0]                  settle_cnt;
  logic [LANES-1:0][TAP_WIDTH-1:0]   shadow;

  logic                 accept, lane_ok, at_max, at_zero;
  logic [LANE_W-1:0]    lane_idx;
  logic [TAP_WIDTH-1:0] cur_tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= idelayctrl_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  // Gating with rdy_sync keeps a command from being taken on the cycle the FSM is bailing out.
  always_comb begin
    cmd_ready = (state == ST_IDLE) && rdy_sync;
    accept    = cmd_valid && cmd_ready;
    lane_ok   = int'(cmd_lane) < LANES;
    lane_idx  = lane_ok ? cmd_lane : '0;
    cur_tap   = shadow[lane_idx];
    at_max    = (cur_tap == TAP_MAX);
    at_zero   = (cur_tap == '0);
  end

  assign tap_value      = shadow;
  assign dly_cntvaluein = shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT_RDY;
      settle_cnt <= '0;
      shadow     <= {LANES{TAP_INIT}};
      dly_ld     <= '0;
      dly_ce     <= '0;
      dly_inc    <= 1'b0;
      init_done  <= 1'b0;
      err_sat    <= 1'b0;
      err_lane   <= 1'b0;
    end else begin
      dly_ld   <= '0;
      dly_ce   <= '0;
      dly_inc  <= 1'b0;
      err_sat  <= 1'b0;
      err_lane <= 1'b0;

      case (state)
        ST_WAIT_RDY: begin
          if (rdy_sync) begin
            dly_ld <= '1;
            state  <= ST_LOAD_SHADOW;
          end
        end
        ST_LOAD_SHADOW, ST_APPLY: begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_IDLE: begin
          if (accept) begin
            state <= ST_APPLY;
            // Everything the APPLY cycle shows is decided here, so later input changes are ignored.
            case (cmd_op)
              OP_LOAD_ALL: begin
                dly_ld <= '1;
                shadow <= {LANES{cmd_tap}};
              end
              OP_LOAD: begin
                if (!lane_ok) err_lane <= 1'b1;
                else begin
                  dly_ld[lane_idx] <= 1'b1;
                  shadow[lane_idx] <= cmd_tap;
                end
              end
              OP_INC: begin
                if (!lane_ok)    err_lane <= 1'b1;
                else if (at_max) err_sat  <= 1'b1;
                else begin
                  dly_ce[lane_idx] <= 1'b1;
                  dly_inc          <= 1'b1;
                  shadow[lane_idx] <= cur_tap + TAP_WIDTH'(1);
                end
              end
              default: begin
                if (!lane_ok)     err_lane <= 1'b1;
                else if (at_zero) err_sat  <= 1'b1;
                else begin
                  dly_ce[lane_idx] <= 1'b1;
                  shadow[lane_idx] <= cur_tap - TAP_WIDTH'(1);
                end
              end
            endcase
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_WAIT_RDY;
      endcase

      // Lost reference clock: abandon whatever is running; the shadow is replayed on return.
      if (!rdy_sync && state != ST_WAIT_RDY) state <= ST_WAIT_RDY;
    end
  end

endmodule

// File: tb/tb_rgmii_idelay_ctrl.sv
// Scoreboard bench for rgmii_idelay_ctrl: each command pushes its expected
// APPLY-cycle outputs, a negedge monitor pops them when the command is accepted.
module tb_rgmii_idelay_ctrl;
  import rgmii_idelay_ctrl_pkg::*;

  logic        clk, rst_n, idelayctrl_rdy;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_lane;
  logic [4:0]  cmd_tap;
  logic [4:0]  dly_ld, dly_ce;
  logic        dly_inc, init_done, err_sat, err_lane;
  logic [24:0] dly_cntvaluein, tap_value;

  rgmii_idelay_ctrl dut (
    .clk(clk), .rst_n(rst_n), .idelayctrl_rdy(idelayctrl_rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lane(cmd_lane), .cmd_tap(cmd_tap), .dly_ld(dly_ld), .dly_ce(dly_ce),
    .dly_inc(dly_inc), .dly_cntvaluein(dly_cntvaluein), .tap_value(tap_value),
    .init_done(init_done), .err_sat(err_sat), .err_lane(err_lane)
  );

  typedef struct {
    logic [4:0]  ld, ce;
    logic        inc, es, el;
    logic [24:0] taps;
  } exp_t;

  exp_t sb[$];
  int   mtap[5];
  int   n_chk = 0, n_bad = 0;
  logic acc_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] pack_taps();
    logic [24:0] v;
    for (int i = 0; i < 5; i++) v[i*5 +: 5] = mtap[i][4:0];
    return v;
  endfunction

  function automatic logic [24:0] all_taps(input logic [4:0] t);
    logic [24:0] v;
    for (int i = 0; i < 5; i++) v[i*5 +: 5] = t;
    return v;
  endfunction

  always @(negedge clk) begin
    if (acc_q) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("apply_ld",   dly_ld,   e.ld);
        chk("apply_ce",   dly_ce,   e.ce);
        chk("apply_inc",  dly_inc,  e.inc);
        chk("apply_esat", err_sat,  e.es);
        chk("apply_elan", err_lane, e.el);
        chk("apply_tap",  tap_value, e.taps);
        chk("apply_cntv", dly_cntvaluein, e.taps);
        chk("ld_ce_excl", dly_ld & dly_ce, 0);
      end
    end
    acc_q = cmd_valid && cmd_ready && rst_n;
  end

  task automatic send(input logic [1:0] op, input logic [2:0] lane, input logic [4:0] tap);
    exp_t e;
    int l, n;
    l = int'(lane);
    e.ld = '0; e.ce = '0; e.inc = 1'b0; e.es = 1'b0; e.el = 1'b0;
    case (op)
      OP_LOAD_ALL: begin
        e.ld = '1;
        for (int i = 0; i < 5; i++) mtap[i] = int'(tap);
      end
      OP_LOAD: begin
        if (l >= 5) e.el = 1'b1;
        else begin e.ld[l] = 1'b1; mtap[l] = int'(tap); end
      end
      OP_INC: begin
        if (l >= 5) e.el = 1'b1;
        else if (mtap[l] == 31) e.es = 1'b1;
        else begin e.ce[l] = 1'b1; e.inc = 1'b1; mtap[l]++; end
      end
      default: begin
        if (l >= 5) e.el = 1'b1;
        else if (mtap[l] == 0) e.es = 1'b1;
        else begin e.ce[l] = 1'b1; mtap[l]--; end
      end
    endcase
    e.taps = pack_taps();
    sb.push_back(e);
    cmd_op = op; cmd_lane = lane; cmd_tap = tap; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_lane = 3'($urandom); cmd_tap = 5'($urandom);
  endtask

  // Called one #1 after the accept edge; checks pulses drop and ready returns 17 edges later.
  task automatic wait_settle();
    @(posedge clk); #1;
    chk("pulse_clr", {dly_ld, dly_ce, dly_inc, err_sat, err_lane}, 0);
    chk("busy_first", cmd_ready, 0);
    repeat (15) @(posedge clk);
    #1 chk("busy_last", cmd_ready, 0);
    @(posedge clk); #1;
    chk("ready_back", cmd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b1; idelayctrl_rdy = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_lane = '0; cmd_tap = '0;
    for (int i = 0; i < 5; i++) mtap[i] = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_pulses", {dly_ld, dly_ce, dly_inc, err_sat, err_lane}, 0);
    chk("rst_init", init_done, 0);
    chk("rst_tap", tap_value, 0);
    chk("rst_cntv", dly_cntvaluein, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1 idelayctrl_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("start_ld_early", dly_ld, 0);
    @(posedge clk); #1;
    chk("start_ld", dly_ld, 5'h1F);
    chk("start_cntv", dly_cntvaluein, 0);
    @(posedge clk); #1;
    chk("start_ld_1cyc", dly_ld, 0);
    repeat (15) @(posedge clk);
    #1 chk("init_early", init_done, 0);
    @(posedge clk); #1;
    chk("init_done", init_done, 1);
    chk("init_ready", cmd_ready, 1);

    send(OP_LOAD, 3'd2, 5'd17); wait_settle();
    send(OP_LOAD, 3'd0, 5'd31); wait_settle();
    send(OP_INC,  3'd0, 5'd0);  wait_settle();
    send(OP_DEC,  3'd1, 5'd0);  wait_settle();
    send(OP_INC,  3'd3, 5'd0);  wait_settle();
    send(OP_DEC,  3'd2, 5'd0);  wait_settle();
    send(OP_LOAD, 3'd4, 5'd1);  wait_settle();
    send(OP_DEC,  3'd4, 5'd0);  wait_settle();
    send(OP_LOAD, 3'd6, 5'd5);  wait_settle();
    send(OP_INC,  3'd7, 5'd0);  wait_settle();
    send(OP_DEC,  3'd5, 5'd0);  wait_settle();
    for (int k = 0; k < 12; k++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), 5'($urandom));
      wait_settle();
    end

    // IDELAYCTRL ready drops mid-settle; shadow must be replayed, not INIT_TAP.
    send(OP_LOAD_ALL, 3'd1, 5'd9);
    repeat (5) @(posedge clk);
    #1 idelayctrl_rdy = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_lane = 3'd0; cmd_tap = 5'd3;
    repeat (30) @(posedge clk);
    #1 chk("drop_ready", cmd_ready, 0);
    chk("drop_ld", dly_ld, 0);
    cmd_valid = 1'b0;
    idelayctrl_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reload_early", dly_ld, 0);
    @(posedge clk); #1;
    chk("reload_ld", dly_ld, 5'h1F);
    chk("reload_cntv", dly_cntvaluein, all_taps(5'd9));
    chk("reload_init", init_done, 1);
    repeat (16) @(posedge clk);
    #1 chk("reload_busy", cmd_ready, 0);
    @(posedge clk); #1;
    chk("reload_ready", cmd_ready, 1);

    // Async reset in the middle of an APPLY cycle.
    send(OP_INC, 3'd0, 5'd0);
    #6 rst_n = 1'b0;
    #1;
    chk("arst_pulses", {dly_ld, dly_ce, dly_inc, err_sat, err_lane}, 0);
    chk("arst_ready", cmd_ready, 0);
    chk("arst_init", init_done, 0);
    chk("arst_tap", tap_value, 0);
    chk("arst_cntv", dly_cntvaluein, 0);
    for (int i = 0; i < 5; i++) mtap[i] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("arst_reload_ld", dly_ld, 5'h1F);
    repeat (17) @(posedge clk);
    #1 chk("arst_init_again", init_done, 1);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
